// File: rtl/pmu_apb_regfile.sv
// APB shadow register file in front of the PMU core; tracks live PMU state between writes.
// Define PMU_APB_STRB_EN to add the pstrb_i port and byte-granular writes.
module pmu_apb_regfile #(
  parameter int REG_WIDTH  = 32,
  parameter int N_REGS     = 12,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                psel_i,
  input  logic                                penable_i,
  input  logic                                pwrite_i,
  input  logic [ADDR_WIDTH-1:0]               paddr_i,
  input  logic [REG_WIDTH-1:0]                pwdata_i,
`ifdef PMU_APB_STRB_EN
  input  logic [REG_WIDTH/8-1:0]              pstrb_i,
`endif
  output logic [REG_WIDTH-1:0]                prdata_o,
  output logic                                pready_o,
  output logic                                pslverr_o,
  output logic [N_REGS-1:0][REG_WIDTH-1:0]    regs_o,
  input  logic [N_REGS-1:0][REG_WIDTH-1:0]    regs_i,
  output logic                                wrapper_we_o
);
  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                           state;
  logic [IDX_W-1:0]                 idx;
  logic                             wr;
  logic                             valid;
  logic [N_REGS-1:0][REG_WIDTH-1:0] shadow;
  logic                             addr_ok;
  logic                             commit;
  logic [REG_WIDTH-1:0]             wdata;

  assign addr_ok = (paddr_i[1:0] == 2'b00) &&
                   ({2'b00, paddr_i[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(N_REGS));

  assign commit = (state == ACCESS) && wr && valid && psel_i && penable_i;

`ifdef PMU_APB_STRB_EN
  function automatic logic [REG_WIDTH-1:0] merge_bytes(input logic [REG_WIDTH-1:0]   old,
                                                       input logic [REG_WIDTH-1:0]   data,
                                                       input logic [REG_WIDTH/8-1:0] strb);
    logic [REG_WIDTH-1:0] r;
    r = old;
    for (int b = 0; b < REG_WIDTH/8; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  assign wdata = merge_bytes(shadow[idx], pwdata_i, pstrb_i);
`else
  assign wdata = pwdata_i;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      idx          <= '0;
      wr           <= 1'b0;
      valid        <= 1'b0;
      prdata_o     <= '0;
      pready_o     <= 1'b0;
      pslverr_o    <= 1'b0;
      wrapper_we_o <= 1'b0;
      shadow       <= '0;
    end else begin
      wrapper_we_o <= commit;
      // Shadows freeze through the commit and strobe cycles so the PMU load is never overwritten by a stale count.
      if (commit)
        shadow[idx] <= wdata;
      else if (!wrapper_we_o)
        shadow <= regs_i;

      case (state)
        IDLE: begin
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
          if (psel_i && !penable_i) begin
            state <= SETUP;
            idx   <= paddr_i[IDX_W+1:2];
            wr    <= pwrite_i;
            valid <= addr_ok;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          pready_o  <= 1'b1;
          pslverr_o <= !valid;
          if (!wr) prdata_o <= valid ? shadow[idx] : '0;
        end
        ACCESS: begin
          state     <= IDLE;
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
        end
      endcase
    end
  end

  assign regs_o = shadow;

endmodule

// File: tb/tb_pmu_apb_regfile.sv
// Self-checking bench for pmu_apb_regfile: directed APB traffic plus random ops against a register model.
module tb_pmu_apb_regfile;
  localparam int N_REGS = 12;
  localparam int RW     = 32;
  localparam int AW     = 32;

  logic                      clk  = 1'b0;
  logic                      rstn = 1'b1;
  logic                      psel = 1'b0;
  logic                      penable = 1'b0;
  logic                      pwrite = 1'b0;
  logic [AW-1:0]             paddr = '0;
  logic [RW-1:0]             pwdata = '0;
`ifdef PMU_APB_STRB_EN
  logic [RW/8-1:0]           pstrb = '1;
`endif
  logic [RW-1:0]             prdata;
  logic                      pready;
  logic                      pslverr;
  logic                      wrapper_we;
  logic [N_REGS-1:0][RW-1:0] regs_o;
  logic [N_REGS-1:0][RW-1:0] pmu;

  logic                      pmu_set = 1'b0;
  logic [3:0]                pmu_set_idx = '0;
  logic [RW-1:0]             pmu_set_val = '0;
  logic                      inc1 = 1'b0;

  logic [RW-1:0]             exp_reg [N_REGS];
  logic [RW-1:0]             last_rdata;
  logic                      last_err;
  int                        checks = 0;
  int                        fails  = 0;

  always #5 clk = ~clk;

  pmu_apb_regfile #(.REG_WIDTH(RW), .N_REGS(N_REGS), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
`ifdef PMU_APB_STRB_EN
    .pstrb_i     (pstrb),
`endif
    .prdata_o    (prdata),
    .pready_o    (pready),
    .pslverr_o   (pslverr),
    .regs_o      (regs_o),
    .regs_i      (pmu),
    .wrapper_we_o(wrapper_we)
  );

  // Stand-in PMU core: loads the shadows on the strobe, otherwise holds, can be poked, and can count reg 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pmu <= '0;
    else if (wrapper_we) pmu <= regs_o;
    else begin
      if (pmu_set) pmu[pmu_set_idx] <= pmu_set_val;
      if (inc1) pmu[1] <= pmu[1] + 1;
    end
  end

  function automatic logic [RW-1:0] merge(input logic [RW-1:0] old, input logic [RW-1:0] data,
                                          input logic [RW/8-1:0] strb);
    logic [RW-1:0] mask;
    mask = '0;
    for (int b = 0; b < RW/8; b++) if (strb[b]) mask = mask | (RW'(8'hFF) << (8*b));
    return (old & ~mask) | (data & mask);
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N_REGS; i++) check($sformatf("%s[%0d]", tag, i), regs_o[i], exp_reg[i]);
  endtask

  // One APB transfer; returns at the falling edge of the cycle right after completion.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [RW-1:0] wdata);
    int rdy;
    int n;
    rdy = 0;
    n = 0;
    last_rdata = '0;
    last_err = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    while (rdy == 0 && n < 8) begin
      @(negedge clk);
      if (pready) begin
        rdy++;
        last_rdata = prdata;
        last_err = pslverr;
      end
      @(posedge clk); #1;
      n++;
    end
    psel = 1'b0; penable = 1'b0;
    check("pready_once", RW'(rdy), 1);
    @(negedge clk);
    check("pready_low_after", RW'(pready), 0);
  endtask

  task automatic do_write(input int idx, input logic [RW-1:0] data, input logic [RW/8-1:0] strb);
    logic [RW/8-1:0] eff;
    logic [RW-1:0]   nv;
`ifdef PMU_APB_STRB_EN
    eff = strb;
    pstrb = strb;
`else
    eff = strb | 4'hF;
`endif
    nv = merge(exp_reg[idx], data, eff);
    xfer(1'b1, AW'(idx*4), data);
    check("wr_slverr", RW'(last_err), 0);
    check("wr_we_pulse", RW'(wrapper_we), 1);
    check("wr_shadow", regs_o[idx], nv);
    exp_reg[idx] = nv;
    @(negedge clk);
    check("wr_we_single", RW'(wrapper_we), 0);
    @(negedge clk);
    check_all("after_wr");
  endtask

  task automatic do_read(input int idx);
    xfer(1'b0, AW'(idx*4), '0);
    check("rd_slverr", RW'(last_err), 0);
    check("rd_data", last_rdata, exp_reg[idx]);
    check("rd_no_we", RW'(wrapper_we), 0);
  endtask

  task automatic bad(input logic wr, input logic [AW-1:0] addr);
    xfer(wr, addr, $urandom);
    check("bad_slverr", RW'(last_err), 1);
    if (!wr) check("bad_rdata", last_rdata, 0);
    check("bad_no_we", RW'(wrapper_we), 0);
    @(negedge clk);
    check("bad_no_we_late", RW'(wrapper_we), 0);
    check_all("after_bad");
  endtask

  task automatic pmu_write(input int idx, input logic [RW-1:0] val);
    pmu_set_idx = 4'(idx); pmu_set_val = val; pmu_set = 1'b1;
    @(posedge clk); #1;
    pmu_set = 1'b0;
    exp_reg[idx] = val;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N_REGS; i++) exp_reg[i] = '0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("rst_regs");
    check("rst_pready", RW'(pready), 0);
    check("rst_we", RW'(wrapper_we), 0);
    check("rst_slverr", RW'(pslverr), 0);
    check("rst_prdata", prdata, 0);
    rstn = 1'b1;
    @(negedge clk);

    do_write(0, 32'h0000_0003, 4'hF);
    pmu_write(1, 32'h55);
    do_read(1);

    // Write while the PMU counts reg 1: written value holds, then tracking resumes with one-cycle lag.
    inc1 = 1'b1;
    repeat (3) @(negedge clk);
`ifdef PMU_APB_STRB_EN
    pstrb = '1;
`endif
    xfer(1'b1, 32'h4, 32'h100);
    check("inc_we", RW'(wrapper_we), 1);
    check("inc_hold0", regs_o[1], 32'h100);
    @(negedge clk);
    check("inc_hold1", regs_o[1], 32'h100);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("inc_follow%0d", k), regs_o[1], 32'h100 + RW'(k - 2));
    end
    inc1 = 1'b0;
    exp_reg[1] = 32'h104;
    @(negedge clk);
    @(negedge clk);
    check_all("inc_stop");

    bad(1'b0, AW'(4*N_REGS));
    bad(1'b0, 32'h2);
    bad(1'b1, AW'(4*N_REGS + 8));
    bad(1'b1, 32'h1);

    // psel dropped during ACCESS: no commit, FSM back to IDLE.
    pmu_write(3, $urandom);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = ~exp_reg[3];
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("drop_pready", RW'(pready), 1);
    @(negedge clk);
    check("drop_no_we", RW'(wrapper_we), 0);
    check("drop_shadow", regs_o[3], exp_reg[3]);
    @(negedge clk);
    check("drop_no_we_late", RW'(wrapper_we), 0);
    do_read(3);

    // Reset in the ACCESS cycle of a write.
    pmu_write(2, 32'h1234_5678);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check("rstmid_pready", RW'(pready), 0);
    check("rstmid_we", RW'(wrapper_we), 0);
    for (int i = 0; i < N_REGS; i++) exp_reg[i] = '0;
    check_all("rstmid_regs");
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid_no_we", RW'(wrapper_we), 0);
    end
    check_all("rstmid_after");

    for (int it = 0; it < 20; it++) begin
      int            op;
      int            idx;
      logic [RW-1:0] d;
      op  = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, N_REGS - 1));
      d   = $urandom;
      case (op)
        0: do_write(idx, d, 4'($urandom_range(0, 15)));
        1: do_read(idx);
        2: pmu_write(idx, d);
        default: bad(1'(it % 2), ($urandom_range(0, 1) == 1) ? AW'(4*(N_REGS + idx))
                                                             : AW'(idx*4 + int'($urandom_range(1, 3))));
      endcase
    end

`ifdef PMU_APB_STRB_EN
    do_write(2, 32'hAABB_CCDD, 4'hF);
    do_write(2, 32'h1122_3344, 4'b0101);
    check("strb_example", regs_o[2], 32'hAA22_CC44);
    do_write(2, $urandom, 4'b0000);
    check("strb_zero", regs_o[2], 32'hAA22_CC44);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
